// File: rtl/memwb_stage.sv
// ============================================================================
// Module   : memwb_stage
// Purpose  : MEM/WB pipeline stage: ALU writeback, local dmem load/store and
//            external bus load/store with stall handshake. Optional bus
//            timeout is enabled by defining MEMWB_BUS_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module memwb_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] iAluResult,
  input  logic [15:0] iStoreData,
  input  logic        iAlutoReg,
  input  logic        iMemtoReg,
  input  logic        iBustoReg,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic        iBusWrite,
  input  logic [3:0]  iWriteBackAddr,
  output logic [7:0]  oDmemAddr,
  output logic [15:0] oDmemWdata,
  output logic        oDmemWren,
  output logic        oDmemRden,
  input  logic [15:0] iDmemQ,
  output logic        oBusReq,
  output logic        oBusWe,
  output logic [15:0] oBusAddr,
  output logic [15:0] oBusWdata,
  input  logic        iBusAck,
  input  logic [15:0] iBusRdata,
  output logic        oWriteBack_en,
  output logic [3:0]  oWriteBackAddr,
  output logic [15:0] oWriteBackData,
  output logic        oStall,
  output logic        oBusErr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEMRD   = 2'd1,
    BUSWAIT = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  dest_q;
  logic        bus_load_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [15:0] bus_addr_q;
  logic [15:0] bus_wdata_q;
  logic        wb_en_q;
  logic [3:0]  wb_addr_q;
  logic [15:0] wb_data_q;
`ifdef MEMWB_BUS_TIMEOUT_EN
  logic [7:0]  tmo_cnt_q;
  logic        bus_err_q;
`endif

  logic w_idle;
  logic w_busop;
  logic unused_inputs;

  // iMemtoReg is implied by iMemRead; kept only for port compatibility
  assign unused_inputs = iMemtoReg;

  assign w_idle  = (state_q == IDLE);
  assign w_busop = iBustoReg | iBusWrite;

  assign oDmemAddr  = iAluResult[7:0];
  assign oDmemWdata = iStoreData;
  assign oDmemRden  = w_idle & iMemRead & ~w_busop;
  assign oDmemWren  = w_idle & iMemWrite & ~iMemRead & ~w_busop;
  assign oStall     = ~w_idle;

  assign oBusReq        = bus_req_q;
  assign oBusWe         = bus_we_q;
  assign oBusAddr       = bus_addr_q;
  assign oBusWdata      = bus_wdata_q;
  assign oWriteBack_en  = wb_en_q;
  assign oWriteBackAddr = wb_addr_q;
  assign oWriteBackData = wb_data_q;
`ifdef MEMWB_BUS_TIMEOUT_EN
  assign oBusErr = bus_err_q;
`else
  assign oBusErr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dest_q      <= 4'd0;
      bus_load_q  <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 16'd0;
      bus_wdata_q <= 16'd0;
      wb_en_q     <= 1'b0;
      wb_addr_q   <= 4'd0;
      wb_data_q   <= 16'd0;
`ifdef MEMWB_BUS_TIMEOUT_EN
      tmo_cnt_q   <= 8'd0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      wb_en_q <= 1'b0;
`ifdef MEMWB_BUS_TIMEOUT_EN
      bus_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (w_busop) begin
            bus_req_q   <= 1'b1;
            bus_we_q    <= iBusWrite;
            bus_addr_q  <= iAluResult;
            bus_wdata_q <= iStoreData;
            bus_load_q  <= ~iBusWrite;
            dest_q      <= iWriteBackAddr;
`ifdef MEMWB_BUS_TIMEOUT_EN
            tmo_cnt_q   <= 8'd0;
`endif
            state_q     <= BUSWAIT;
          end else if (iMemRead) begin
            dest_q  <= iWriteBackAddr;
            state_q <= MEMRD;
          end else if (iAlutoReg) begin
            wb_en_q   <= (iWriteBackAddr != 4'd0);
            wb_addr_q <= iWriteBackAddr;
            wb_data_q <= iAluResult;
          end
        end
        MEMRD: begin
          wb_en_q   <= (dest_q != 4'd0);
          wb_addr_q <= dest_q;
          wb_data_q <= iDmemQ;
          state_q   <= IDLE;
        end
        BUSWAIT: begin
          // ack is checked first so it wins over a coincident timeout
          if (iBusAck) begin
            bus_req_q <= 1'b0;
            state_q   <= IDLE;
            if (bus_load_q) begin
              wb_en_q   <= (dest_q != 4'd0);
              wb_addr_q <= dest_q;
              wb_data_q <= iBusRdata;
            end
`ifdef MEMWB_BUS_TIMEOUT_EN
          end else if (tmo_cnt_q == 8'd254) begin
            bus_req_q <= 1'b0;
            bus_err_q <= 1'b1;
            state_q   <= IDLE;
            if (bus_load_q) begin
              wb_en_q   <= (dest_q != 4'd0);
              wb_addr_q <= dest_q;
              wb_data_q <= 16'hFFFF;
            end
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_memwb_stage.sv
// Bench for memwb_stage: transaction-level reference model checked every cycle,
// plus directed scenarios pinned with literal expectations.
`default_nettype none

module tb_memwb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] iAluResult = '0, iStoreData = '0;
  logic        iAlutoReg = 0, iMemtoReg = 0, iBustoReg = 0;
  logic        iMemRead = 0, iMemWrite = 0, iBusWrite = 0;
  logic [3:0]  iWriteBackAddr = '0;
  logic [7:0]  oDmemAddr;
  logic [15:0] oDmemWdata, iDmemQ;
  logic        oDmemWren, oDmemRden;
  logic        oBusReq, oBusWe, iBusAck = 0;
  logic [15:0] oBusAddr, oBusWdata, iBusRdata = '0;
  logic        oWriteBack_en;
  logic [3:0]  oWriteBackAddr;
  logic [15:0] oWriteBackData;
  logic        oStall, oBusErr;

  memwb_stage dut (
    .clk(clk), .rst_n(rst_n),
    .iAluResult(iAluResult), .iStoreData(iStoreData),
    .iAlutoReg(iAlutoReg), .iMemtoReg(iMemtoReg), .iBustoReg(iBustoReg),
    .iMemRead(iMemRead), .iMemWrite(iMemWrite), .iBusWrite(iBusWrite),
    .iWriteBackAddr(iWriteBackAddr),
    .oDmemAddr(oDmemAddr), .oDmemWdata(oDmemWdata), .oDmemWren(oDmemWren),
    .oDmemRden(oDmemRden), .iDmemQ(iDmemQ),
    .oBusReq(oBusReq), .oBusWe(oBusWe), .oBusAddr(oBusAddr), .oBusWdata(oBusWdata),
    .iBusAck(iBusAck), .iBusRdata(iBusRdata),
    .oWriteBack_en(oWriteBack_en), .oWriteBackAddr(oWriteBackAddr),
    .oWriteBackData(oWriteBackData), .oStall(oStall), .oBusErr(oBusErr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_on = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // synchronous RAM seen by the DUT (1-cycle read latency)
  logic [15:0] ram [256];
  always @(posedge clk) begin
    if (oDmemWren) ram[oDmemAddr] <= oDmemWdata;
    iDmemQ <= ram[oDmemAddr];
  end

  // ---------------- reference model: outstanding operation + expected writeback
  localparam int K_NONE = 0, K_LD = 1, K_BLD = 2, K_BST = 3;
  int          m_kind = K_NONE;
  int          m_wait = 0;
  logic [3:0]  m_dest = '0;
  logic [15:0] m_ldata = '0, m_baddr = '0, m_bwdata = '0;
  logic [15:0] ref_mem [256];
  logic        exp_en = 0, exp_err = 0;
  logic [3:0]  exp_addr = '0;
  logic [15:0] exp_data = '0;

  task retire(input logic [3:0] d, input logic [15:0] v);
    exp_en   = (d != 4'd0);
    exp_addr = d;
    exp_data = v;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_kind = K_NONE; m_wait = 0;
      exp_en = 0; exp_err = 0; exp_addr = '0; exp_data = '0;
    end else begin
      exp_en = 0; exp_err = 0;
      if (m_kind == K_NONE) begin
        if (iBustoReg || iBusWrite) begin
          m_kind = iBusWrite ? K_BST : K_BLD;
          m_dest = iWriteBackAddr; m_baddr = iAluResult; m_bwdata = iStoreData; m_wait = 0;
        end else if (iMemRead) begin
          m_kind = K_LD; m_dest = iWriteBackAddr; m_ldata = ref_mem[iAluResult[7:0]];
        end else begin
          if (iMemWrite) ref_mem[iAluResult[7:0]] = iStoreData;
          if (iAlutoReg) retire(iWriteBackAddr, iAluResult);
        end
      end else if (m_kind == K_LD) begin
        retire(m_dest, m_ldata);
        m_kind = K_NONE;
      end else if (iBusAck) begin
        if (m_kind == K_BLD) retire(m_dest, iBusRdata);
        m_kind = K_NONE;
      end else begin
        m_wait++;
`ifdef MEMWB_BUS_TIMEOUT_EN
        if (m_wait == 255) begin
          exp_err = 1;
          if (m_kind == K_BLD) retire(m_dest, 16'hFFFF);
          m_kind = K_NONE;
        end
`endif
      end
    end
  end

  // ---------------- per-cycle compare
  always @(negedge clk) begin
    if (chk_on) begin
      logic bus_now, idle_now, busop, e_rd, e_wr;
      idle_now = (m_kind == K_NONE);
      bus_now  = (m_kind == K_BLD) || (m_kind == K_BST);
      busop    = iBustoReg | iBusWrite;
      e_rd     = rst_n && idle_now && iMemRead && !busop;
      e_wr     = rst_n && idle_now && iMemWrite && !iMemRead && !busop;
      chk("stall", oStall, !idle_now);
      chk("wb_en", oWriteBack_en, exp_en);
      if (exp_en) begin
        chk("wb_addr", oWriteBackAddr, exp_addr);
        chk("wb_data", oWriteBackData, exp_data);
      end
      chk("bus_err", oBusErr, exp_err);
      chk("bus_req", oBusReq, bus_now);
      if (bus_now) begin
        chk("bus_addr", oBusAddr, m_baddr);
        chk("bus_wdata", oBusWdata, m_bwdata);
        chk("bus_we", oBusWe, m_kind == K_BST);
      end
      chk("dmem_rden", oDmemRden, e_rd);
      chk("dmem_wren", oDmemWren, e_wr);
      if (e_rd || e_wr) chk("dmem_addr", oDmemAddr, iAluResult[7:0]);
      if (e_wr) chk("dmem_wdata", oDmemWdata, iStoreData);
    end
  end

  // ---------------- stimulus helpers
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic clr();
    iAluResult = '0; iStoreData = '0; iWriteBackAddr = '0;
    iAlutoReg = 0; iMemtoReg = 0; iBustoReg = 0;
    iMemRead = 0; iMemWrite = 0; iBusWrite = 0;
  endtask

  task automatic alu(input logic [15:0] v, input logic [3:0] d);
    iAlutoReg = 1; iAluResult = v; iWriteBackAddr = d;
    tick(); clr();
  endtask

  task automatic store(input logic [7:0] a, input logic [15:0] v);
    iMemWrite = 1; iAluResult = {8'h00, a}; iStoreData = v;
    tick(); clr();
  endtask

  task automatic load(input logic [7:0] a, input logic [3:0] d);
    iMemRead = 1; iMemtoReg = 1; iAluResult = {8'h00, a}; iWriteBackAddr = d;
    tick(); clr();
  endtask

  task automatic busop(input logic wr, input logic [15:0] a, input logic [15:0] v,
                       input logic [3:0] d);
    iBustoReg = ~wr; iBusWrite = wr; iAluResult = a; iStoreData = v; iWriteBackAddr = d;
    tick(); clr();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) begin ram[i] = '0; ref_mem[i] = '0; end
    #1 rst_n = 0;
    chk_on = 1;
    tick(); tick();
    chk("rst_stall", oStall, 0);
    chk("rst_wb_en", oWriteBack_en, 0);
    chk("rst_wb_data", oWriteBackData, 16'h0000);
    chk("rst_bus_req", oBusReq, 0);
    chk("rst_bus_addr", oBusAddr, 16'h0000);
    chk("rst_bus_err", oBusErr, 0);
    rst_n = 1;
    tick();

    // ALU writeback
    alu(16'h1234, 4'd3); #1;
    chk("alu_en", oWriteBack_en, 1);
    chk("alu_addr", oWriteBackAddr, 4'd3);
    chk("alu_data", oWriteBackData, 16'h1234);
    chk("alu_stall", oStall, 0);
    tick(); #1;
    chk("alu_pulse", oWriteBack_en, 0);
    alu(16'hFFFF, 4'd0); #1;
    chk("alu_r0", oWriteBack_en, 0);
    alu(16'h0F0F, 4'd15); alu(16'h8001, 4'd1);

    // store then load
    iMemWrite = 1; iAluResult = 16'h0010; iStoreData = 16'hBEEF; #1;
    chk("st_wren", oDmemWren, 1);
    chk("st_addr", oDmemAddr, 8'h10);
    tick(); clr();
    load(8'h10, 4'd5); #1;
    chk("ld_stall", oStall, 1);
    chk("ld_wait_en", oWriteBack_en, 0);
    tick(); #1;
    chk("ld_stall_done", oStall, 0);
    chk("ld_en", oWriteBack_en, 1);
    chk("ld_addr", oWriteBackAddr, 4'd5);
    chk("ld_data", oWriteBackData, 16'hBEEF);
    tick();
    for (int i = 0; i < 4; i++) store(8'h20 + 8'(i), 16'h1111 * 16'(i + 1));
    for (int i = 3; i >= 0; i--) begin load(8'h20 + 8'(i), 4'(i)); tick(); end
    alu(16'h0042, 4'd9); load(8'hFF, 4'd6); tick();

    // stray ack while idle is ignored
    iBusAck = 1; iBusRdata = 16'hDEAD; tick(); iBusAck = 0; tick();

    // bus load, ack in the 4th wait cycle
    busop(1'b0, 16'h8000, 16'h0000, 4'd7); #1;
    chk("bld_req", oBusReq, 1);
    chk("bld_addr", oBusAddr, 16'h8000);
    chk("bld_stall", oStall, 1);
    tick(); tick(); tick();
    iBusAck = 1; iBusRdata = 16'hA5A5;
    tick(); iBusAck = 0; #1;
    chk("bld_req_drop", oBusReq, 0);
    chk("bld_en", oWriteBack_en, 1);
    chk("bld_addr_wb", oWriteBackAddr, 4'd7);
    chk("bld_data", oWriteBackData, 16'hA5A5);
    tick();

    // bus store, ack after 2 cycles: no writeback
    busop(1'b1, 16'h1234, 16'hCAFE, 4'd4); #1;
    chk("bst_we", oBusWe, 1);
    chk("bst_wdata", oBusWdata, 16'hCAFE);
    tick(); iBusAck = 1; tick(); iBusAck = 0; #1;
    chk("bst_no_wb", oWriteBack_en, 0);
    tick();

    // reset in 2nd bus wait cycle
    busop(1'b1, 16'h4444, 16'h5555, 4'd8);
    tick();
    rst_n = 0; #1;
    chk("rst_mid_req", oBusReq, 0);
    chk("rst_mid_stall", oStall, 0);
    tick(); rst_n = 1; tick(); #1;
    chk("rst_after_stall", oStall, 0);
    chk("rst_after_wb", oWriteBack_en, 0);
    alu(16'h7777, 4'd2); tick();

`ifdef MEMWB_BUS_TIMEOUT_EN
    busop(1'b0, 16'h9000, 16'h0000, 4'd2);
    n = 0;
    while (oStall && n < 400) begin tick(); n++; end
    #1;
    chk("tmo_cycles", n, 255);
    chk("tmo_err", oBusErr, 1);
    chk("tmo_en", oWriteBack_en, 1);
    chk("tmo_addr", oWriteBackAddr, 4'd2);
    chk("tmo_data", oWriteBackData, 16'hFFFF);
    chk("tmo_stall", oStall, 0);
    tick(); #1;
    chk("tmo_err_pulse", oBusErr, 0);
    busop(1'b0, 16'h9002, 16'h0000, 4'd4);
    for (int i = 0; i < 254; i++) tick();
    iBusAck = 1; iBusRdata = 16'h1357;
    tick(); iBusAck = 0; #1;
    chk("tmo_ack_err", oBusErr, 0);
    chk("tmo_ack_data", oWriteBackData, 16'h1357);
    tick();
`else
    busop(1'b0, 16'h9000, 16'h0000, 4'd2);
    n = 0;
    while (oStall && n < 300) begin tick(); n++; end
    #1;
    chk("notmo_wait", n, 300);
    chk("notmo_req", oBusReq, 1);
    chk("notmo_err", oBusErr, 0);
    iBusAck = 1; iBusRdata = 16'h2468;
    tick(); iBusAck = 0; #1;
    chk("notmo_data", oWriteBackData, 16'h2468);
    tick();
`endif

    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
